// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding, width helper and defaults for the round-robin arbiter
package arb_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_t;
  localparam int ARB_DEF_N = 4;
  localparam int ARB_DEF_MAX_HOLD = 8;
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-and-priority-encode winner selection over the effective requests
module rr_pick #(
  parameter int N = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   ereq,
  input  logic [IDW-1:0] ptr,
  input  logic [N-1:0]   excl,
  input  logic           fixed_prio,
  output logic           found,
  output logic [IDW-1:0] idx
);
  logic [N-1:0]   cand;
  logic [N-1:0]   rot;
  logic [IDW-1:0] start;
  int             off;
  int             sum;
  assign cand  = ereq & ~excl;
  assign start = fixed_prio ? '0 : ptr;
  assign found = |cand;
  // rotate so the start index lands at bit 0, take the lowest set bit, map back modulo N
  always_comb begin
    rot = N'({cand, cand} >> start);
    off = 0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = i;
    sum = int'(start) + off;
    idx = IDW'(sum >= N ? sum - N : sum);
  end
endmodule

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-way round-robin / fixed-priority arbiter with mask and bounded hold
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int N = ARB_DEF_N,
  parameter int MAX_HOLD = ARB_DEF_MAX_HOLD,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic           fixed_prio,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           hold_expired
);
  localparam int HW = safe_clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  arb_state_t     state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] ptr;
  logic [HW-1:0]  hold_cnt;
  logic [N-1:0]   ereq;
  logic [N-1:0]   own_oh;
  logic           own_req;
  logic           expire;
  logic           found;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] nxt_ptr;
  assign ereq    = req & ~mask;
  assign own_oh  = N'(1) << owner;
  assign own_req = ereq[owner];
  assign expire  = (MAX_HOLD != 0) && (hold_cnt == HMAX);
  assign nxt_ptr = (idx == IDW'(N - 1)) ? '0 : idx + 1'b1;
  assign busy    = (state == ARB_GRANT);
  assign gnt     = busy ? own_oh : '0;
  assign gnt_id  = owner;
  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .ereq      (ereq),
    .ptr       (ptr),
    .excl      (busy ? own_oh : '0),
    .fixed_prio(fixed_prio),
    .found     (found),
    .idx       (idx)
  );
  // grant issue, release, hand-over and hold-limit pre-emption
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= ARB_IDLE;
      owner        <= '0;
      ptr          <= '0;
      hold_cnt     <= '0;
      hold_expired <= 1'b0;
    end else begin
      hold_expired <= 1'b0;
      if (state == ARB_IDLE || !own_req || (expire && found)) begin
        if (found) begin
          state        <= ARB_GRANT;
          owner        <= idx;
          ptr          <= nxt_ptr;
          hold_cnt     <= HW'(1);
          hold_expired <= (state == ARB_GRANT) && own_req;
        end else begin
          state <= ARB_IDLE;
        end
      end else if (MAX_HOLD != 0 && hold_cnt != HMAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: directed and random checks of two arbiter instances against a behavioural model
module tb_rr_arbiter_n;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] mask = '0;
  logic       fp = 1'b0;
  logic [3:0] gnt4, gnt0;
  logic [1:0] id4, id0;
  logic       busy4, busy0, hx4, hx0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         mb[2], mo[2], mp[2], mc[2], mx[2];
  int         mh[2] = '{4, 0};

  always #5 clk = ~clk;

  rr_arbiter_n #(.N(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .fixed_prio(fp),
    .gnt(gnt4), .gnt_id(id4), .busy(busy4), .hold_expired(hx4)
  );
  rr_arbiter_n #(.N(4), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .fixed_prio(fp),
    .gnt(gnt0), .gnt_id(id0), .busy(busy0), .hold_expired(hx0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] er, input int ex, input int p, input logic f);
    int c;
    for (int k = 0; k < 4; k++) begin
      c = f ? k : (p + k) % 4;
      if (c != ex && er[c]) return c;
    end
    return -1;
  endfunction

  task automatic give(input int m, input int w);
    mb[m] = 1; mo[m] = w; mp[m] = (w + 1) % 4; mc[m] = 1;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mb[m] = 0; mo[m] = 0; mp[m] = 0; mc[m] = 0; mx[m] = 0;
    end
  endtask

  task automatic model_step();
    logic [3:0] er;
    int w;
    er = req & ~mask;
    for (int m = 0; m < 2; m++) begin
      mx[m] = 0;
      if (mb[m] == 0) begin
        w = pick(er, -1, mp[m], fp);
        if (w >= 0) give(m, w);
      end else if (!er[mo[m]]) begin
        w = pick(er, mo[m], mp[m], fp);
        if (w >= 0) give(m, w); else mb[m] = 0;
      end else begin
        w = pick(er, mo[m], mp[m], fp);
        if (mh[m] != 0 && mc[m] >= mh[m] && w >= 0) begin
          give(m, w);
          mx[m] = 1;
        end else mc[m]++;
      end
    end
  endtask

  task automatic check_models();
    logic [3:0] g;
    logic [1:0] id;
    logic b, h;
    for (int m = 0; m < 2; m++) begin
      g  = m ? gnt0 : gnt4;
      id = m ? id0 : id4;
      b  = m ? busy0 : busy4;
      h  = m ? hx0 : hx4;
      chk(m ? "m0_gnt" : "m4_gnt", 32'(g), mb[m] != 0 ? 32'(1) << mo[m] : 32'd0);
      chk(m ? "m0_busy" : "m4_busy", 32'(b), 32'(mb[m]));
      chk(m ? "m0_hexp" : "m4_hexp", 32'(h), 32'(mx[m]));
      chk(m ? "m0_onehot" : "m4_onehot", 32'($countones(g) <= 1), 32'd1);
      if (mb[m] != 0) chk(m ? "m0_id" : "m4_id", 32'(id), 32'(mo[m]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_models();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt4", 32'(gnt4), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    chk("init_gnt", 32'(gnt4), 32'd0);
    chk("init_id", 32'(id4), 32'd0);
    chk("init_busy", 32'(busy4), 32'd0);
    chk("init_hexp", 32'(hx4), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0010;
    cyc();
    chk("first_gnt", 32'(gnt4), 32'h2);
    cyc();
    do_reset();
    cyc();
    chk("post_rst_gnt", 32'(gnt4), 32'h2);
    req = 4'b1111;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc();
      chk("cont_gnt", 32'(gnt4), 32'(1) << ((i / 4) % 4));
      chk("cont_hexp", 32'(hx4), 32'(i % 4 == 0 && i > 0));
    end
    req = 4'b0100;
    for (int i = 0; i < 21; i++) begin
      cyc();
      chk("lone_gnt", 32'(gnt4), 32'h4);
      chk("lone_hexp", 32'(hx4), 32'd0);
    end
    fp = 1'b1;
    req = 4'b1111;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("fp_gnt", 32'(gnt0), 32'h1);
      chk("fp_id", 32'(id0), 32'd0);
    end
    req = 4'b1110;
    cyc();
    chk("fp_hand_gnt", 32'(gnt0), 32'h2);
    chk("fp_hand_id", 32'(id0), 32'd1);
    chk("fp_hand_busy", 32'(busy0), 32'd1);
    fp = 1'b0;
    req = 4'b0100;
    do_reset();
    cyc();
    req = 4'b0110;
    cyc();
    chk("mask_pre", 32'(gnt4), 32'h4);
    mask = 4'b0100;
    cyc();
    chk("mask_gnt", 32'(gnt4), 32'h2);
    mask = 4'b0000;
    req = 4'b1000;
    do_reset();
    cyc();
    chk("wrap_own3", 32'(gnt4), 32'h8);
    req = 4'b0000;
    cyc();
    chk("wrap_idle", 32'(busy4), 32'd0);
    req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("wrap_gnt0", 32'(gnt4), 32'h1);
    end
    cyc();
    chk("wrap_gnt3", 32'(gnt4), 32'h8);
    chk("wrap_hexp", 32'(hx4), 32'd1);
    for (int i = 0; i < 400; i++) begin
      req  = 4'($urandom);
      mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      fp   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0) req = req | 4'($urandom);
      cyc();
      if (i % 97 == 96) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
